// File: rtl/schedule_dispatcher.sv
// schedule_dispatcher: steps the layer-block scheduler and dispatches one job per active block to NPU/CIM
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i, abort_i         run start pulse, return-to-idle override
//   schedule_*               request/response handshake with the layer-block scheduler
//   npu_job_*, npu_done_i    NPU job valid/ready, layer/type, completion pulse
//   cim_job_*, cim_done_i    CIM job valid/ready, layer/type, completion pulse
//   busy_o, done_o, error_o  status: not idle, run complete pulse, sticky watchdog error
//   step_count_o             completed schedule steps in the current run (saturating)
module schedule_dispatcher #(
    parameter int unsigned LAYER_W        = 32,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    output logic               schedule_valid_o,
    input  logic               schedule_ready_i,
    input  logic               block0_finish_i,
    input  logic               block1_finish_i,
    input  logic               schedule_type_i,
    input  logic               block_type_i,
    input  logic [LAYER_W-1:0] block0_schedule_layer_i,
    input  logic [LAYER_W-1:0] block1_schedule_layer_i,
    output logic               npu_job_valid_o,
    input  logic               npu_job_ready_i,
    output logic [LAYER_W-1:0] npu_job_layer_o,
    output logic               npu_job_type_o,
    input  logic               npu_done_i,
    output logic               cim_job_valid_o,
    input  logic               cim_job_ready_i,
    output logic [LAYER_W-1:0] cim_job_layer_o,
    output logic               cim_job_type_o,
    input  logic               cim_done_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    output logic [CNT_W-1:0]   step_count_o
);
    typedef enum logic [2:0] {IDLE, REQ, ISSUE, WAIT, DONE, ERR} state_e;

    state_e             state_q, state_d;
    logic               sched_valid_q, sched_valid_d;
    logic               npu_valid_q, npu_valid_d, cim_valid_q, cim_valid_d;
    logic               npu_pend_q, npu_pend_d, cim_pend_q, cim_pend_d;
    logic               job_type_q, job_type_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [LAYER_W-1:0] npu_layer_q, npu_layer_d, cim_layer_q, cim_layer_d;
    logic [CNT_W-1:0]   step_q, step_d;
    logic [31:0]        wd_q, wd_d;
    logic               npu_req, cim_req, wd_hit;

    // schedule_type swaps which block feeds which engine; a finished block gets no job
    assign npu_req = ~(schedule_type_i ? block1_finish_i : block0_finish_i);
    assign cim_req = ~(schedule_type_i ? block0_finish_i : block1_finish_i);
    assign wd_hit  = (TIMEOUT_CYCLES != 0) && (wd_q + 32'd1 == TIMEOUT_CYCLES);

    always_comb begin
        state_d       = state_q;
        sched_valid_d = sched_valid_q;
        npu_valid_d   = npu_valid_q & ~npu_job_ready_i;
        cim_valid_d   = cim_valid_q & ~cim_job_ready_i;
        // a done pulse in the acceptance cycle cancels the pending flag it would set
        npu_pend_d    = (npu_pend_q | (npu_valid_q & npu_job_ready_i)) & ~npu_done_i;
        cim_pend_d    = (cim_pend_q | (cim_valid_q & cim_job_ready_i)) & ~cim_done_i;
        npu_layer_d   = npu_layer_q;
        cim_layer_d   = cim_layer_q;
        job_type_d    = job_type_q;
        step_d        = step_q;
        wd_d          = wd_q;
        err_d         = err_q;
        done_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d       = REQ;
                    sched_valid_d = 1'b1;
                    step_d        = '0;
                end
            end
            REQ: begin
                if (schedule_ready_i) begin
                    sched_valid_d = 1'b0;
                    job_type_d    = block_type_i;
                    npu_layer_d   = schedule_type_i ? block1_schedule_layer_i : block0_schedule_layer_i;
                    cim_layer_d   = schedule_type_i ? block0_schedule_layer_i : block1_schedule_layer_i;
                    if (block0_finish_i && block1_finish_i) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        wd_d        = '0;
                        npu_valid_d = npu_req;
                        cim_valid_d = cim_req;
                    end
                end
            end
            ISSUE, WAIT: begin
                wd_d = wd_q + 32'd1;
                if (wd_hit) begin
                    state_d     = ERR;
                    err_d       = 1'b1;
                    npu_valid_d = 1'b0;
                    cim_valid_d = 1'b0;
                end else if (state_q == ISSUE && !npu_valid_d && !cim_valid_d) begin
                    state_d = WAIT;
                end else if (state_q == WAIT && !npu_pend_q && !cim_pend_q) begin
                    state_d       = REQ;
                    sched_valid_d = 1'b1;
                    step_d        = &step_q ? step_q : step_q + CNT_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: ;
        endcase
        if (abort_i) begin
            state_d       = IDLE;
            sched_valid_d = 1'b0;
            npu_valid_d   = 1'b0;
            cim_valid_d   = 1'b0;
            npu_pend_d    = 1'b0;
            cim_pend_d    = 1'b0;
            err_d         = 1'b0;
            done_d        = 1'b0;
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            sched_valid_q <= 1'b0;
            npu_valid_q   <= 1'b0;
            cim_valid_q   <= 1'b0;
            npu_pend_q    <= 1'b0;
            cim_pend_q    <= 1'b0;
            npu_layer_q   <= '0;
            cim_layer_q   <= '0;
            job_type_q    <= 1'b0;
            step_q        <= '0;
            wd_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            sched_valid_q <= sched_valid_d;
            npu_valid_q   <= npu_valid_d;
            cim_valid_q   <= cim_valid_d;
            npu_pend_q    <= npu_pend_d;
            cim_pend_q    <= cim_pend_d;
            npu_layer_q   <= npu_layer_d;
            cim_layer_q   <= cim_layer_d;
            job_type_q    <= job_type_d;
            step_q        <= step_d;
            wd_q          <= wd_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign schedule_valid_o = sched_valid_q;
    assign npu_job_valid_o  = npu_valid_q;
    assign npu_job_layer_o  = npu_layer_q;
    assign npu_job_type_o   = job_type_q;
    assign cim_job_valid_o  = cim_valid_q;
    assign cim_job_layer_o  = cim_layer_q;
    assign cim_job_type_o   = job_type_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign error_o          = err_q;
    assign step_count_o     = step_q;
endmodule
